// File: rtl/mmv_pkg.sv
// Shared constants for the RAM responder: busy LFSR width, taps and default seed.
// No logic of its own, so no latency.
// No flow control here; users apply backpressure through s_busy.
package mmv_pkg;

    localparam int LFSR_W = 16;

    // Polynomial x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form (state bits 0,2,3,5).
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'h002D;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        return {^(cur & LFSR_TAPS), cur[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/mmv_ram_rd_pipe.sv
// Read-return shift pipeline: a valid/data pair moves one stage per clk.
// Latency DEPTH cycles from in_val to out_val.
// Never stalls and has no backpressure; up to DEPTH reads can be in flight.
module mmv_ram_rd_pipe #(
    parameter int DEPTH  = 2,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_val,
    input  logic [DWIDTH-1:0] in_dat,
    output logic              out_val,
    output logic [DWIDTH-1:0] out_dat
);

    logic [DEPTH-1:0]  val_q;
    logic [DEPTH-1:0]  val_d;
    logic [DWIDTH-1:0] dat_q [DEPTH];
    logic [DWIDTH-1:0] dat_d [DEPTH];

    always_comb begin
        val_d    = '0;
        val_d[0] = in_val;
        dat_d[0] = in_dat;
        for (int i = 1; i < DEPTH; i++) begin
            val_d[i] = val_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    // Only the valid bits are cleared; stale data behind a zero valid is harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    always_ff @(posedge clk) begin
        dat_q <= dat_d;
    end

    assign out_val = val_q[DEPTH-1];
    assign out_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/mmv_ram_responder.sv
// Memory-mapped RAM slave with programmable read latency, random busy and read-data error mask.
// Write lands at the accept edge; read data returns RDLAT cycles after accept.
// s_busy is a registered LFSR-driven stall; held requests are accepted once it drops.
module mmv_ram_responder
    import mmv_pkg::*;
#(
    parameter int                AWIDTH    = 8,
    parameter int                DWIDTH    = 8,
    parameter int                RDLAT     = 2,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] s_addr,
    input  logic              s_wreq,
    input  logic [DWIDTH-1:0] s_wdat,
    input  logic              s_rreq,
    output logic [DWIDTH-1:0] s_rdat,
    output logic              s_rval,
    output logic              s_busy,
    input  logic              busy_en,
    input  logic [DWIDTH-1:0] err_mask,
    output logic              proto_err
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic              busy_q;
    logic              busy_d;
    logic              proto_q;
    logic              proto_d;
    logic [DWIDTH-1:0] rdat_q;
    logic [DWIDTH-1:0] rdat_d;

    logic              accept;
    logic              wr_en;
    logic              rd_en;
    logic [DWIDTH-1:0] rd_sample;
    logic              pipe_val;
    logic [DWIDTH-1:0] pipe_dat;
    logic [DWIDTH-1:0] rd_out;

    always_comb begin
        accept    = ~reset & (s_wreq | s_rreq) & ~busy_q;
        wr_en     = accept & s_wreq;
        // A write+read collision keeps the write and drops the read.
        rd_en     = accept & s_rreq & ~s_wreq;
        proto_d   = accept & s_wreq & s_rreq;
        rd_sample = mem[s_addr];

        lfsr_d = lfsr_step(lfsr_q);
        busy_d = busy_en & lfsr_q[0] & lfsr_q[1];

        // Mask is applied as the data leaves the pipe; the last value is held between pulses.
        rd_out = pipe_val ? (pipe_dat ^ err_mask) : rdat_q;
        rdat_d = rd_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q  <= LFSR_SEED;
            busy_q  <= 1'b0;
            proto_q <= 1'b0;
            rdat_q  <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            busy_q  <= busy_d;
            proto_q <= proto_d;
            rdat_q  <= rdat_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[s_addr] <= s_wdat;
        end
    end

    mmv_ram_rd_pipe #(
        .DEPTH  (RDLAT),
        .DWIDTH (DWIDTH)
    ) u_rd_pipe (
        .clk     (clk),
        .reset   (reset),
        .in_val  (rd_en),
        .in_dat  (rd_sample),
        .out_val (pipe_val),
        .out_dat (pipe_dat)
    );

    assign s_rval    = pipe_val;
    assign s_rdat    = rd_out;
    assign s_busy    = busy_q;
    assign proto_err = proto_q;

endmodule

// File: tb/tb_mmv_ram_responder.sv
// Bench for mmv_ram_responder: directed scenarios plus a randomized busy run,
// all outputs compared every cycle against a transaction-level model.
module tb_mmv_ram_responder;

    localparam int          AW    = 8;
    localparam int          DW    = 8;
    localparam int          RDLAT = 2;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] s_addr = '0;
    logic          s_wreq = 1'b0;
    logic [DW-1:0] s_wdat = '0;
    logic          s_rreq = 1'b0;
    logic [DW-1:0] s_rdat;
    logic          s_rval;
    logic          s_busy;
    logic          busy_en = 1'b0;
    logic [DW-1:0] err_mask = '0;
    logic          proto_err;

    always #5 clk = ~clk;

    mmv_ram_responder #(
        .AWIDTH    (AW),
        .DWIDTH    (DW),
        .RDLAT     (RDLAT),
        .LFSR_SEED (SEED)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_addr    (s_addr),
        .s_wreq    (s_wreq),
        .s_wdat    (s_wdat),
        .s_rreq    (s_rreq),
        .s_rdat    (s_rdat),
        .s_rval    (s_rval),
        .s_busy    (s_busy),
        .busy_en   (busy_en),
        .err_mask  (err_mask),
        .proto_err (proto_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic [7:0]  dat;
    } rd_t;

    rd_t         pend[$];
    logic [7:0]  m_mem [256];
    logic [15:0] m_lfsr;
    logic        m_busy;
    logic        m_proto;
    logic [7:0]  m_hold;
    logic        m_acc;
    bit          mon_en = 0;
    bit          mon_ev;
    logic [7:0]  mon_ed;
    int          rval_cnt = 0;
    int          busy_cnt = 0;

    initial begin
        foreach (m_mem[i]) m_mem[i] = 8'h00;
    end

    // Reference model: evaluated at every active edge from the request rules.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_lfsr  = SEED;
                m_busy  = 1'b0;
                m_proto = 1'b0;
                m_hold  = 8'h00;
                pend.delete();
            end else begin
                m_acc   = (s_wreq || s_rreq) && !m_busy;
                m_proto = m_acc && s_wreq && s_rreq;
                if (m_acc && s_rreq && !s_wreq) pend.push_back('{due: cyc + RDLAT, dat: m_mem[s_addr]});
                if (m_acc && s_wreq) m_mem[s_addr] = s_wdat;
                m_busy = busy_en && m_lfsr[0] && m_lfsr[1];
                m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
            end
            cyc++;
        end
    end

    // Cycle monitor: compares every output against the model mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                mon_ev = (pend.size() > 0) && (pend[0].due == cyc);
                if (mon_ev) begin
                    mon_ed = pend[0].dat ^ err_mask;
                    pend.pop_front();
                    m_hold = mon_ed;
                end else begin
                    mon_ed = m_hold;
                end
                checks++;
                if (s_rval !== mon_ev) begin
                    errors++;
                    $display("FAIL mon_rval cyc=%0d got=%b exp=%b", cyc, s_rval, mon_ev);
                end
                checks++;
                if (s_rdat !== mon_ed) begin
                    errors++;
                    $display("FAIL mon_rdat cyc=%0d got=%h exp=%h", cyc, s_rdat, mon_ed);
                end
                checks++;
                if (s_busy !== m_busy) begin
                    errors++;
                    $display("FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, s_busy, m_busy);
                end
                checks++;
                if (proto_err !== m_proto) begin
                    errors++;
                    $display("FAIL mon_proto cyc=%0d got=%b exp=%b", cyc, proto_err, m_proto);
                end
                if (s_rval === 1'b1) rval_cnt++;
                if (s_busy === 1'b1) busy_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_wreq = 1'b0;
        s_rreq = 1'b0;
    endtask

    // Master side: hold a request until it is presented in a non-busy cycle.
    task automatic issue(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d,
                         output bit ok);
        s_wreq = w;
        s_rreq = r;
        s_addr = a;
        s_wdat = d;
        ok = 0;
        for (int k = 0; k < 64 && !ok; k++) begin
            if (s_busy === 1'b0) ok = 1;
            tick();
        end
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        mon_en = 1;
        tick();
        reset = 1'b0;
        checks++;
        if (s_rval !== 1'b0) begin errors++; $display("FAIL reset_rval got=%b exp=0", s_rval); end
        checks++;
        if (s_rdat !== 8'h00) begin errors++; $display("FAIL reset_rdat got=%h exp=00", s_rdat); end
        checks++;
        if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", s_busy); end
        checks++;
        if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto got=%b exp=0", proto_err); end
    endtask

    task automatic test_basic();
        int acc_cyc;
        int seen_cyc;
        int seen_n;
        int busy_seen;
        logic [7:0] seen_dat;
        busy_en = 1'b0;
        s_addr = 8'h10; s_wdat = 8'hA5; s_wreq = 1'b1;
        tick();
        s_wreq = 1'b0; s_rreq = 1'b1; s_addr = 8'h10;
        acc_cyc = cyc;
        busy_seen = (s_busy === 1'b1) ? 1 : 0;
        tick();
        idle();
        seen_n = 0; seen_cyc = -1; seen_dat = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (s_busy === 1'b1) busy_seen++;
            if (s_rval === 1'b1) begin
                seen_n++;
                if (seen_cyc < 0) begin seen_cyc = cyc; seen_dat = s_rdat; end
            end
            tick();
        end
        checks++;
        if (seen_n != 1) begin errors++; $display("FAIL basic_count got=%0d exp=1", seen_n); end
        checks++;
        if (seen_cyc != acc_cyc + RDLAT) begin
            errors++; $display("FAIL basic_latency got=%0d exp=%0d", seen_cyc - acc_cyc, RDLAT);
        end
        checks++;
        if (seen_dat !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h exp=a5", seen_dat); end
        checks++;
        if (busy_seen != 0) begin errors++; $display("FAIL basic_busy got=%0d exp=0", busy_seen); end
    endtask

    task automatic test_back_to_back();
        int first;
        int p_cyc[$];
        logic [7:0] p_dat[$];
        logic [7:0] expd;
        busy_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_wreq = 1'b1; s_addr = 8'(i); s_wdat = 8'(i);
            tick();
        end
        idle();
        first = cyc;
        for (int i = 0; i < 8 + RDLAT + 4; i++) begin
            if (i < 8) begin s_rreq = 1'b1; s_addr = 8'(i); end else idle();
            if (s_rval === 1'b1) begin p_cyc.push_back(cyc); p_dat.push_back(s_rdat); end
            tick();
        end
        idle();
        checks++;
        if (p_cyc.size() != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", p_cyc.size()); end
        for (int k = 0; k < p_cyc.size() && k < 8; k++) begin
            expd = 8'(k);
            checks++;
            if (p_cyc[k] != first + RDLAT + k || p_dat[k] !== expd) begin
                errors++;
                $display("FAIL b2b_pulse%0d got cyc=%0d dat=%h exp cyc=%0d dat=%h",
                         k, p_cyc[k], p_dat[k], first + RDLAT + k, expd);
            end
        end
    endtask

    task automatic test_err_inject();
        int n;
        logic [7:0] got;
        busy_en = 1'b0;
        s_wreq = 1'b1; s_addr = 8'h20; s_wdat = 8'h80;
        tick();
        s_wreq = 1'b0;
        err_mask = 8'h01;
        s_rreq = 1'b1; s_addr = 8'h20;
        tick();
        idle();
        n = 0; got = 8'h00;
        for (int i = 0; i < RDLAT + 3; i++) begin
            if (s_rval === 1'b1) begin n++; got = s_rdat; end
            tick();
        end
        err_mask = 8'h00;
        checks++;
        if (n != 1 || got !== 8'h81) begin
            errors++; $display("FAIL err_inject got n=%0d dat=%h exp n=1 dat=81", n, got);
        end
    endtask

    task automatic test_proto_err();
        int n;
        logic [7:0] got;
        busy_en = 1'b0;
        s_wreq = 1'b1; s_rreq = 1'b1; s_addr = 8'h05; s_wdat = 8'h3C;
        tick();
        idle();
        checks++;
        if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_pulse got=%b exp=1", proto_err); end
        n = 0;
        for (int i = 0; i < RDLAT + 3; i++) begin
            if (i == 1) begin
                checks++;
                if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_width got=%b exp=0", proto_err); end
            end
            if (s_rval === 1'b1) n++;
            tick();
        end
        checks++;
        if (n != 0) begin errors++; $display("FAIL proto_no_rval got=%0d exp=0", n); end
        s_rreq = 1'b1; s_addr = 8'h05;
        tick();
        idle();
        n = 0; got = 8'h00;
        for (int i = 0; i < RDLAT + 3; i++) begin
            if (s_rval === 1'b1) begin n++; got = s_rdat; end
            tick();
        end
        checks++;
        if (n != 1 || got !== 8'h3C) begin
            errors++; $display("FAIL proto_readback got n=%0d dat=%h exp n=1 dat=3c", n, got);
        end
    endtask

    task automatic test_busy_random();
        bit ok;
        int rd_acc;
        int rv0;
        int b0;
        int c0;
        int duty;
        logic [7:0] wa;
        logic [7:0] ra;
        busy_en = 1'b0;
        for (int a = 0; a < 256; a++) begin
            issue(1'b1, 1'b0, 8'(a), 8'($urandom), ok);
        end
        busy_en = 1'b1;
        rd_acc = 0;
        rv0 = rval_cnt; b0 = busy_cnt; c0 = cyc;
        for (int p = 0; p < 1000; p++) begin
            wa = 8'($urandom);
            issue(1'b1, 1'b0, wa, 8'($urandom), ok);
            if (!ok) begin errors++; checks++; $display("FAIL busy_wr_timeout pair=%0d", p); end
            ra = ($urandom_range(1, 0) == 1) ? wa : 8'($urandom);
            issue(1'b0, 1'b1, ra, 8'h00, ok);
            if (ok) rd_acc++;
            else begin errors++; checks++; $display("FAIL busy_rd_timeout pair=%0d", p); end
        end
        duty = ((busy_cnt - b0) * 100) / (cyc - c0);
        for (int i = 0; i < RDLAT + 4; i++) tick();
        checks++;
        if (rval_cnt - rv0 != rd_acc) begin
            errors++; $display("FAIL busy_rval_count got=%0d exp=%0d", rval_cnt - rv0, rd_acc);
        end
        checks++;
        if (duty < 20 || duty > 30) begin
            errors++; $display("FAIL busy_duty got=%0d%% exp=20..30%%", duty);
        end
        busy_en = 1'b0;
    endtask

    task automatic test_reset_midflight();
        int n;
        logic seq_a [40];
        logic seq_b [40];
        logic seq_r [40];
        logic [15:0] l;
        busy_en = 1'b0;
        s_wreq = 1'b1; s_addr = 8'h30; s_wdat = 8'h5A;
        tick();
        s_wreq = 1'b0; s_rreq = 1'b1;
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({s_rval, s_busy, proto_err} !== 3'b000 || s_rdat !== 8'h00) begin
            errors++;
            $display("FAIL midflight_outs got rval=%b busy=%b proto=%b rdat=%h exp all 0",
                     s_rval, s_busy, proto_err, s_rdat);
        end
        n = 0;
        for (int i = 0; i < RDLAT + 3; i++) begin
            if (s_rval === 1'b1) n++;
            tick();
        end
        checks++;
        if (n != 0) begin errors++; $display("FAIL midflight_no_rval got=%0d exp=0", n); end

        l = SEED;
        seq_r[0] = 1'b0;
        for (int k = 1; k < 40; k++) begin
            seq_r[k] = l[0] & l[1];
            l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        end
        busy_en = 1'b1;
        reset = 1'b1; tick(); reset = 1'b0;
        for (int k = 0; k < 40; k++) begin seq_a[k] = s_busy; tick(); end
        reset = 1'b1; tick(); reset = 1'b0;
        for (int k = 0; k < 40; k++) begin seq_b[k] = s_busy; tick(); end
        busy_en = 1'b0;
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (seq_a[k] !== seq_r[k] || seq_b[k] !== seq_r[k]) begin
                errors++;
                $display("FAIL lfsr_restart k=%0d got a=%b b=%b exp=%b", k, seq_a[k], seq_b[k], seq_r[k]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_err_inject();
        test_proto_err();
        test_busy_random();
        test_reset_midflight();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmv_ram_responder.md
Name: mmv_ram_responder

Overview:
Memory-mapped RAM slave: the responder end of the team's addr/wreq/wdat/rreq/rdat/rval/busy master interface.
- Backed by an internal 2**AWIDTH x DWIDTH array.
- Read latency is fixed and programmable.
- Optional pseudo-random busy insertion and a read-data bit-error injection mask.
- Used as the bench-side partner of the RAM testers and as a behavioural RAM stand-in at subsystem level.

Parameters:
- AWIDTH, 8: address width; array depth = 2**AWIDTH.
- DWIDTH, 8: data width.
- RDLAT, 2: read latency in clk cycles from accept to rval; legal range 1..16.
- LFSR_SEED, 16'hACE1: reset value of the busy LFSR; must be nonzero.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- s_addr  in  AWIDTH  request address.
- s_wreq  in  1  write request.
- s_wdat  in  DWIDTH  write data.
- s_rreq  in  1  read request.
- s_rdat  out  DWIDTH  read data, qualified by s_rval.
- s_rval  out  1  read data valid, one-cycle pulse per accepted read.
- s_busy  out  1  request not accepted this cycle.
- busy_en  in  1  1 = pseudo-random busy insertion, 0 = s_busy held low.
- err_mask  in  DWIDTH  XOR-ed into returned read data (fault injection; 0 = transparent).
- proto_err  out  1  one-cycle pulse: s_wreq and s_rreq both asserted in an accepted cycle.

Behaviour:
- Clock/reset: single clock; reset is synchronous and active-high. Name clk/reset as above.
- Reset values: s_rval=0, s_rdat=0, s_busy=0, proto_err=0; LFSR=LFSR_SEED; read pipeline cleared. Array contents are not reset; simulation initial value is 0.
- Reset mid-operation: all in-flight reads are discarded and no s_rval issues for them. Array writes already performed are retained.
- Accept rule: a request is accepted in cycle t when (s_wreq | s_rreq) & ~s_busy. Requests during s_busy are ignored; the master holds them.
- Busy generation:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle while not in reset.
  - s_busy is a register: s_busy <= busy_en & lfsr[0] & lfsr[1], giving about 25% duty.
  - When busy_en=0, s_busy <= 0.
  - s_busy does not depend combinationally on any input.
- Write: accepted s_wreq stores mem[s_addr] <= s_wdat at the accept edge.
- Read:
  - An accepted s_rreq (with s_wreq=0) samples mem[s_addr] at the accept edge.
  - s_rval=1 and s_rdat = sample ^ err_mask appear exactly RDLAT cycles later, i.e. in cycle t+RDLAT.
  - err_mask is sampled when the data leaves the pipeline, not at accept.
- Pipelining: one read may be accepted every cycle; the pipeline never stalls, so up to RDLAT reads are in flight. s_rval is independent of s_busy.
- s_rdat holds its last value when s_rval=0.
- Read-after-write: a write at t followed by a read of the same address at t+1 returns the new data.
- Simultaneous s_wreq & s_rreq when accepted:
  - The write is performed; the read is dropped and produces no s_rval.
  - proto_err=1 in cycle t+1.
- Address wrap: the full AWIDTH address is used, with no aliasing or out-of-range case.

Decomposition:
- Package mmv_pkg holds the LFSR width constant (16), the tap mask, and the default seed.
- Sub-module mmv_ram_rd_pipe: RDLAT-deep valid/data shift pipeline. Inputs: clk, reset, in_val, in_dat. Outputs: out_val, out_dat.
- Array and LFSR live in the top module.

Test Plan:
- Basic write/read: reset, busy_en=0, RDLAT=2, write 8'hA5 @0x10, then read @0x10 next cycle -> s_rval=1 exactly 2 cycles after read accept, s_rdat=8'hA5, s_busy never 1.
- Back-to-back reads: busy_en=0, preload addr 0..7 with 8'h00..8'h07, issue 8 consecutive reads -> 8 consecutive s_rval pulses with data 00..07 in order, first at accept+RDLAT.
- Busy insertion: busy_en=1, master holds each request until ~s_busy, 1000 random write/read pairs -> every read matches the last write to its address; rval count equals accepted-read count; observed busy duty 20-30%.
- Error injection: err_mask=8'h01, read an address holding 8'h80 -> s_rdat=8'h81. Pair with the RAM data-bus tester to confirm it reports fault.
- Protocol error: s_wreq=s_rreq=1, s_wdat=8'h3C @0x05, s_busy=0 -> proto_err pulse one cycle later, no s_rval, later read of 0x05 returns 8'h3C.
- Reset mid-flight: accept read, assert reset the next cycle for one cycle -> no s_rval ever appears for that read; all outputs 0 the cycle after reset; the LFSR busy sequence restarts identically from LFSR_SEED.
